// File: rtl/botoes_condicionador.sv
// Button conditioner: 2-flop synchroniser, debounce filter and multi-press rejection,
// producing one-hot held levels plus single-cycle jogada/multipla pulses.
module botoes_condicionador #(
    parameter int DEBOUNCE_CICLOS = 20,
    parameter int N_BOTOES        = 4
) (
    input  logic                clockFPGA,
    input  logic                reset,
    input  logic [N_BOTOES-1:0] botoes_in,
    input  logic                habilita,
    output logic [N_BOTOES-1:0] botoes_out,
    output logic                jogada,
    output logic                multipla,
    output logic [1:0]          db_estado
);

    localparam int CW = $clog2(DEBOUNCE_CICLOS + 1);
    localparam logic [CW-1:0] CNT_UM     = CW'(1);
    localparam logic [CW-1:0] CNT_ACEITA = CW'(DEBOUNCE_CICLOS - 1);
    localparam logic [CW-1:0] CNT_SOLTA  = CW'(DEBOUNCE_CICLOS);

    typedef enum logic [1:0] {
        OCIOSO      = 2'd0,
        FILTRA      = 2'd1,
        PRESSIONADO = 2'd2,
        SOLTA       = 2'd3
    } estado_t;

    estado_t             estado;
    logic [N_BOTOES-1:0] s1, s2, cand;
    logic [CW-1:0]       cnt;

    assign db_estado = estado;

    always_ff @(posedge clockFPGA) begin
        if (reset) begin
            s1         <= '0;
            s2         <= '0;
            cand       <= '0;
            cnt        <= '0;
            estado     <= OCIOSO;
            botoes_out <= '0;
            jogada     <= 1'b0;
            multipla   <= 1'b0;
        end else begin
            s1       <= botoes_in;
            s2       <= s1;
            jogada   <= 1'b0;
            multipla <= 1'b0;
            if (!habilita) begin
                estado     <= SOLTA;
                cnt        <= '0;
                botoes_out <= '0;
            end else begin
                case (estado)
                    OCIOSO: begin
                        if (s2 != '0) begin
                            cand   <= s2;
                            cnt    <= '0;
                            estado <= FILTRA;
                        end
                    end
                    FILTRA: begin
                        if (s2 != cand) begin
                            if (s2 == '0) begin
                                estado <= OCIOSO;
                            end else begin
                                cand <= s2;
                                cnt  <= '0;
                            end
                        end else if (cnt < CNT_ACEITA) begin
                            cnt <= cnt + CNT_UM;
                        end else begin
                            cnt <= '0;
                            if ($onehot(cand)) begin
                                estado     <= PRESSIONADO;
                                botoes_out <= cand;
                                jogada     <= 1'b1;
                            end else begin
                                estado   <= SOLTA;
                                multipla <= 1'b1;
                            end
                        end
                    end
                    // Release needs D+1 consecutive zero samples, mirroring press acceptance.
                    PRESSIONADO, SOLTA: begin
                        if (s2 != '0) begin
                            cnt <= '0;
                        end else if (cnt == CNT_SOLTA) begin
                            estado     <= OCIOSO;
                            botoes_out <= '0;
                            cnt        <= '0;
                        end else begin
                            cnt <= cnt + CNT_UM;
                        end
                    end
                    default: estado <= OCIOSO;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_botoes_condicionador.sv
// Directed + random stimulus for botoes_condicionador, checked every cycle against a
// run-length reference model.
`timescale 1us/1ns
module tb_botoes_condicionador;

    localparam int D = 20;
    localparam int N = 4;

    logic         clockFPGA = 1'b0;
    logic         reset;
    logic         habilita;
    logic [N-1:0] botoes_in;
    logic [N-1:0] botoes_out;
    logic         jogada;
    logic         multipla;
    logic [1:0]   db_estado;

    botoes_condicionador #(.DEBOUNCE_CICLOS(D), .N_BOTOES(N)) dut (
        .clockFPGA (clockFPGA),
        .reset     (reset),
        .botoes_in (botoes_in),
        .habilita  (habilita),
        .botoes_out(botoes_out),
        .jogada    (jogada),
        .multipla  (multipla),
        .db_estado (db_estado)
    );

    always #500 clockFPGA = ~clockFPGA;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int jog_cnt, mul_cnt, jog_edge, mul_edge, fall_edge;
    int k, r;
    logic [N-1:0] prev_out = '0;

    // Reference model: mode 0 idle/filtering, 1 accepted press held, 2 waiting for release.
    int           m_mode = 0;
    int           m_run  = 0;
    int           m_rel  = 0;
    logic [N-1:0] m_cand = '0;
    logic [N-1:0] m_out  = '0;
    logic         m_jog  = 1'b0;
    logic         m_mul  = 1'b0;
    logic [N-1:0] m_s1   = '0;
    logic [N-1:0] m_s2   = '0;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s edge %0d got %0h expected %0h", tag, edge_n, got, exp);
        end
    endtask

    task automatic model_step();
        if (reset) begin
            m_mode = 0; m_run = 0; m_rel = 0; m_cand = '0;
            m_out = '0; m_jog = 1'b0; m_mul = 1'b0; m_s1 = '0; m_s2 = '0;
        end else begin
            m_jog = 1'b0;
            m_mul = 1'b0;
            if (!habilita) begin
                m_mode = 2; m_rel = 0; m_run = 0; m_out = '0;
            end else if (m_mode == 0) begin
                if (m_s2 == '0) m_run = 0;
                else if (m_run > 0 && m_s2 == m_cand) m_run++;
                else begin m_cand = m_s2; m_run = 1; end
                if (m_run == D + 1) begin
                    m_run = 0;
                    m_rel = 0;
                    if ($countones(m_cand) == 1) begin
                        m_mode = 1; m_out = m_cand; m_jog = 1'b1;
                    end else begin
                        m_mode = 2; m_mul = 1'b1;
                    end
                end
            end else begin
                if (m_s2 == '0) m_rel++;
                else m_rel = 0;
                if (m_rel == D + 1) begin
                    m_mode = 0; m_out = '0; m_rel = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = botoes_in;
        end
    endtask

    function automatic logic [1:0] m_estado();
        if (m_mode == 1) return 2'd2;
        if (m_mode == 2) return 2'd3;
        return (m_run > 0) ? 2'd1 : 2'd0;
    endfunction

    task automatic cycle(input logic [N-1:0] b, input logic h, input logic rs, input int n);
        repeat (n) begin
            botoes_in = b;
            habilita  = h;
            reset     = rs;
            @(posedge clockFPGA);
            edge_n++;
            model_step();
            @(negedge clockFPGA);
            chk("botoes_out", 8'(botoes_out), 8'(m_out));
            chk("jogada", 8'(jogada), 8'(m_jog));
            chk("multipla", 8'(multipla), 8'(m_mul));
            chk("db_estado", 8'(db_estado), 8'(m_estado()));
            if (jogada === 1'b1) begin jog_cnt++; jog_edge = edge_n; end
            if (multipla === 1'b1) begin mul_cnt++; mul_edge = edge_n; end
            if (prev_out != '0 && botoes_out == '0) fall_edge = edge_n;
            prev_out = botoes_out;
        end
    endtask

    task automatic clr();
        jog_cnt = 0; mul_cnt = 0; jog_edge = -1; mul_edge = -1; fall_edge = -1;
    endtask

    logic [N-1:0] pats [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0101, 4'b0000};

    initial begin
        botoes_in = '0; habilita = 1'b1; reset = 1'b1;
        @(negedge clockFPGA);

        // 1: reset then idle
        cycle(4'b0000, 1'b1, 1'b1, 1);
        chk("rst_estado", 8'(db_estado), 8'd0);
        cycle(4'b0000, 1'b1, 1'b0, 50);

        // 2: clean press and release
        clr();
        k = edge_n + 1;
        cycle(4'b0010, 1'b1, 1'b0, 200);
        r = edge_n + 1;
        cycle(4'b0000, 1'b1, 1'b0, 40);
        chk("t2_jog_cnt", 8'(jog_cnt), 8'd1);
        chk("t2_jog_edge", 8'(jog_edge - k), 8'(D + 2));
        chk("t2_fall_edge", 8'(fall_edge - r), 8'(D + 2));

        // 3: bouncing then stable
        clr();
        for (int i = 0; i < 12; i++)
            cycle((i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b1, 1'b0, 5);
        chk("t3_bounce_jog", 8'(jog_cnt), 8'd0);
        k = edge_n + 1;
        cycle(4'b0100, 1'b1, 1'b0, 100);
        chk("t3_out", 8'(botoes_out), 8'b0100);
        chk("t3_jog_cnt", 8'(jog_cnt), 8'd1);
        chk("t3_jog_edge", 8'(jog_edge - k), 8'(D + 2));
        cycle(4'b0000, 1'b1, 1'b0, 30);

        // 4: two buttons at once
        clr();
        k = edge_n + 1;
        cycle(4'b0101, 1'b1, 1'b0, 100);
        chk("t4_estado", 8'(db_estado), 8'd3);
        cycle(4'b0000, 1'b1, 1'b0, 30);
        chk("t4_mul_cnt", 8'(mul_cnt), 8'd1);
        chk("t4_mul_edge", 8'(mul_edge - k), 8'(D + 2));
        chk("t4_jog_cnt", 8'(jog_cnt), 8'd0);

        // 5: press too short
        clr();
        cycle(4'b1000, 1'b1, 1'b0, 15);
        cycle(4'b0000, 1'b1, 1'b0, 30);
        chk("t5_jog_cnt", 8'(jog_cnt), 8'd0);
        chk("t5_estado", 8'(db_estado), 8'd0);

        // 6: disable while held, then new press, then reset mid-press
        clr();
        cycle(4'b0001, 1'b1, 1'b0, 40);
        chk("t6_jog_first", 8'(jog_cnt), 8'd1);
        cycle(4'b0001, 1'b0, 1'b0, 10);
        cycle(4'b0001, 1'b1, 1'b0, 40);
        chk("t6_out_held", 8'(botoes_out), 8'd0);
        chk("t6_jog_held", 8'(jog_cnt), 8'd1);
        cycle(4'b0000, 1'b1, 1'b0, 30);
        clr();
        cycle(4'b0010, 1'b1, 1'b0, 40);
        chk("t6_jog_new", 8'(jog_cnt), 8'd1);
        cycle(4'b0010, 1'b1, 1'b1, 1);
        chk("t6_rst_out", 8'(botoes_out), 8'd0);
        chk("t6_rst_estado", 8'(db_estado), 8'd0);
        cycle(4'b0010, 1'b1, 1'b0, 40);
        chk("t6_jog_reacc", 8'(jog_cnt), 8'd2);
        cycle(4'b0000, 1'b1, 1'b0, 30);

        // Random patterns with glitches, occasional disable and rare reset
        for (int s = 0; s < 60; s++) begin
            logic [N-1:0] p;
            int len;
            p   = pats[$urandom_range(0, 5)];
            len = $urandom_range(3, 45);
            for (int c = 0; c < len; c++) begin
                logic [N-1:0] b;
                b = p;
                if ($urandom_range(0, 19) == 0) b = b ^ (4'(1) << $urandom_range(0, N - 1));
                cycle(b, ($urandom_range(0, 29) != 0), ($urandom_range(0, 199) == 0), 1);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
